// File: rtl/bus_txn_sequencer_pkg.sv
// Shared constants for the bus transfer sequencer: state encoding, grant codes,
// slave ids and default bus geometry.
package bus_txn_sequencer_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    typedef enum logic [1:0] {
        GNT_NONE    = 2'b00,
        GNT_M1      = 2'b01,
        GNT_M2      = 2'b10,
        GNT_ILLEGAL = 2'b11
    } grant_e;

    localparam logic [1:0] SLAVE_0 = 2'd0;
    localparam logic [1:0] SLAVE_1 = 2'd1;
    localparam logic [1:0] SLAVE_2 = 2'd2;
    localparam logic [1:0] SLAVE_3 = 2'd3;

    function automatic logic [3:0] slave_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/bus_txn_sequencer_if.sv
// Bus bundle between the arbiter/masters, the sequencer and the four slave ports.
// The sequencer uses the master modport; the surrounding fabric uses slave.
interface bus_txn_sequencer_if
    import bus_txn_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [1:0]        bus_grant;
    logic [1:0]        slave_sel;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [3:0]        s_ready;
    logic [DATA_W-1:0] s_rdata;

    logic [3:0]        s_valid;
    logic              s_rw;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [1:0]        m_done;
    logic [DATA_W-1:0] m_rdata;
    logic              m_error;
    logic              bus_release;

    modport master (
        input  bus_grant, slave_sel, m_rw, m_addr, m_wdata, s_ready, s_rdata,
        output s_valid, s_rw, s_addr, s_wdata, m_done, m_rdata, m_error, bus_release
    );

    modport slave (
        output bus_grant, slave_sel, m_rw, m_addr, m_wdata, s_ready, s_rdata,
        input  s_valid, s_rw, s_addr, s_wdata, m_done, m_rdata, m_error, bus_release
    );

endinterface

// File: rtl/bus_timeout_counter.sv
// Counts cycles a slave strobe has been held; expired marks the last allowed cycle.
module bus_timeout_counter
    import bus_txn_sequencer_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] count;

    // Holds at the last value so a stalled enable can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 8'd0;
        end else if (enable && (count != LAST)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/bus_txn_sequencer.sv
// Runs one granted bus transfer: latches the command, strobes the target slave,
// waits for ready or timeout, then reports completion and releases the bus.
module bus_txn_sequencer
    import bus_txn_sequencer_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    bus_txn_sequencer_if.master bus,
    output logic                seq_busy,
    output logic                proto_err,
    output logic [7:0]          err_count
);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic              owner_q;
    logic [1:0]        sel_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic grant_ok;
    logic strobing;
    logic completing;
    logic sel_ready;
    logic expired;

    assign grant_ok   = (bus.bus_grant == GNT_M1) || (bus.bus_grant == GNT_M2);
    assign strobing   = (state == ST_ADDR) || (state == ST_WAIT);
    assign completing = (state == ST_DONE) || (state == ST_ERR);
    assign sel_ready  = bus.s_ready[sel_q];

    bus_timeout_counter #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!strobing),
        .enable  (strobing),
        .expired (expired)
    );

    // Ready from the selected slave always wins over an expiring timeout.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant_ok) state_next = ST_ADDR;
            ST_ADDR: state_next = sel_ready ? ST_DONE : ST_WAIT;
            ST_WAIT: begin
                if (sel_ready) begin
                    state_next = ST_DONE;
                end else if (expired) begin
                    state_next = ST_ERR;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The command is captured only in IDLE, so it stays frozen for the whole transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner_q   <= 1'b0;
            sel_q     <= 2'd0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            proto_err <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state <= state_next;
            if ((state == ST_IDLE) && grant_ok) begin
                owner_q <= (bus.bus_grant == GNT_M2);
                sel_q   <= bus.slave_sel;
                rw_q    <= bus.m_rw;
                addr_q  <= bus.m_addr;
                wdata_q <= bus.m_wdata;
            end
            if ((state == ST_IDLE) && (bus.bus_grant == GNT_ILLEGAL)) begin
                proto_err <= 1'b1;
            end
            if (strobing && sel_ready && !rw_q) begin
                rdata_q <= bus.s_rdata;
            end
            if ((state == ST_ERR) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    assign bus.s_valid     = strobing ? slave_onehot(sel_q) : 4'b0000;
    assign bus.s_rw        = rw_q;
    assign bus.s_addr      = addr_q;
    assign bus.s_wdata     = wdata_q;
    assign bus.m_done      = completing ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.m_rdata     = ((state == ST_DONE) && !rw_q) ? rdata_q : '0;
    assign bus.m_error     = (state == ST_ERR);
    assign bus.bus_release = completing;
    assign seq_busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_bus_txn_sequencer.sv
// Self-checking bench: a transaction-level model predicts every output each cycle
// from the command and the cycle at which the selected slave answers.
module tb_bus_txn_sequencer;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       seq_busy;
    logic       proto_err;
    logic [7:0] err_count;

    bus_txn_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    bus_txn_sequencer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if.master),
        .seq_busy  (seq_busy),
        .proto_err (proto_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    logic [3:0]        exp_s_valid;
    logic              exp_s_rw;
    logic [ADDR_W-1:0] exp_s_addr;
    logic [DATA_W-1:0] exp_s_wdata;
    logic [1:0]        exp_m_done;
    logic [DATA_W-1:0] exp_m_rdata;
    logic              exp_m_error;
    logic              exp_bus_release;
    logic              exp_seq_busy;
    logic              exp_proto_err;
    int                exp_err_count;

    int         run_cnt = 0;
    int         last_valid_cycles = 0;
    int         done_count = 0;
    logic [1:0] last_done = 2'b00;
    logic [7:0] last_rdata = 8'h00;
    logic       last_err = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h @%0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison plus a small monitor feeding the hand-computed checks.
    always @(negedge clk) begin
        if (check_en) begin
            check_output("s_valid", 32'(bus_if.s_valid), 32'(exp_s_valid));
            check_output("s_rw", 32'(bus_if.s_rw), 32'(exp_s_rw));
            check_output("s_addr", 32'(bus_if.s_addr), 32'(exp_s_addr));
            check_output("s_wdata", 32'(bus_if.s_wdata), 32'(exp_s_wdata));
            check_output("m_done", 32'(bus_if.m_done), 32'(exp_m_done));
            check_output("m_rdata", 32'(bus_if.m_rdata), 32'(exp_m_rdata));
            check_output("m_error", 32'(bus_if.m_error), 32'(exp_m_error));
            check_output("bus_release", 32'(bus_if.bus_release), 32'(exp_bus_release));
            check_output("seq_busy", 32'(seq_busy), 32'(exp_seq_busy));
            check_output("proto_err", 32'(proto_err), 32'(exp_proto_err));
            check_output("err_count", 32'(err_count), 32'(exp_err_count));
        end
        if (rst) begin
            run_cnt = 0;
        end else if (bus_if.s_valid != 4'b0000) begin
            run_cnt++;
        end
        if (bus_if.m_done != 2'b00) begin
            last_done         = bus_if.m_done;
            last_rdata        = bus_if.m_rdata;
            last_err          = bus_if.m_error;
            last_valid_cycles = run_cnt;
            run_cnt           = 0;
            done_count++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_expect();
        exp_s_valid     = 4'b0000;
        exp_s_rw        = 1'b0;
        exp_s_addr      = '0;
        exp_s_wdata     = '0;
        exp_m_done      = 2'b00;
        exp_m_rdata     = '0;
        exp_m_error     = 1'b0;
        exp_bus_release = 1'b0;
        exp_seq_busy    = 1'b0;
        exp_proto_err   = 1'b0;
        exp_err_count   = 0;
    endtask

    task automatic scramble_inputs();
        bus_if.slave_sel = 2'($urandom);
        bus_if.m_rw      = 1'($urandom);
        bus_if.m_addr    = ADDR_W'($urandom);
        bus_if.m_wdata   = DATA_W'($urandom);
        bus_if.s_ready   = 4'($urandom);
        bus_if.s_rdata   = DATA_W'($urandom);
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        bus_if.bus_grant = 2'b00;
        repeat (cycles) step();
        clear_expect();
        rst = 1'b0;
    endtask

    // One idle cycle driving grant g (00 or 11); other inputs are junk.
    task automatic idle_cycle(input logic [1:0] g);
        scramble_inputs();
        bus_if.bus_grant = g;
        step();
        if (g == 2'b11) exp_proto_err = 1'b1;
        bus_if.bus_grant = 2'b00;
    endtask

    // ready_at: strobe cycle index (0 = first) at which the selected slave answers.
    // reset_at: strobe cycle index during which rst is held high, or -1.
    task automatic apply_stimulus(input int owner, input logic [1:0] sel, input logic rw,
                                  input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                                  input int ready_at, input logic [DATA_W-1:0] rdata,
                                  input int reset_at, input bit full_noise);
        logic [3:0] mask;
        bit         is_err;
        bit         was_reset;
        int         k;
        mask      = 4'b0001 << sel;
        is_err    = 1'b0;
        was_reset = 1'b0;
        scramble_inputs();
        bus_if.bus_grant = (owner == 1) ? 2'b01 : 2'b10;
        bus_if.slave_sel = sel;
        bus_if.m_rw      = rw;
        bus_if.m_addr    = addr;
        bus_if.m_wdata   = wdata;
        step();
        exp_s_valid  = mask;
        exp_s_rw     = rw;
        exp_s_addr   = addr;
        exp_s_wdata  = wdata;
        exp_seq_busy = 1'b1;
        k = 0;
        while (1) begin
            scramble_inputs();
            bus_if.bus_grant = 2'($urandom);
            bus_if.s_ready   = full_noise ? ~mask : (4'($urandom) & ~mask);
            if (k == ready_at) begin
                bus_if.s_ready = bus_if.s_ready | mask;
                bus_if.s_rdata = rdata;
            end
            if (k == reset_at) rst = 1'b1;
            step();
            if (k == reset_at) begin
                rst = 1'b0;
                clear_expect();
                was_reset = 1'b1;
                break;
            end
            if (k == ready_at) break;
            if (k == TIMEOUT - 1) begin
                is_err = 1'b1;
                break;
            end
            k++;
        end
        if (!was_reset) begin
            exp_s_valid     = 4'b0000;
            exp_m_done      = (owner == 1) ? 2'b01 : 2'b10;
            exp_bus_release = 1'b1;
            exp_m_error     = is_err;
            exp_m_rdata     = (!is_err && !rw) ? rdata : '0;
            scramble_inputs();
            bus_if.bus_grant = 2'($urandom);
            step();
            exp_m_done      = 2'b00;
            exp_bus_release = 1'b0;
            exp_m_error     = 1'b0;
            exp_m_rdata     = '0;
            exp_seq_busy    = 1'b0;
            if (is_err && exp_err_count < 255) exp_err_count++;
        end
        bus_if.bus_grant = 2'b00;
    endtask

    initial begin
        int ra;
        int ra_lim;
        int rs;
        int done_before;
        rst = 1'b1;
        bus_if.bus_grant = 2'b00;
        scramble_inputs();
        clear_expect();
        apply_reset(2);
        check_en = 1'b1;

        check_output("reset_s_valid", 32'(bus_if.s_valid), 32'h0);
        check_output("reset_seq_busy", 32'(seq_busy), 32'h0);
        check_output("reset_err_count", 32'(err_count), 32'h0);
        idle_cycle(2'b00);

        // Zero-wait write to slave 2.
        apply_stimulus(1, 2'd2, 1'b1, 12'h0A5, 8'h3C, 0, 8'h00, -1, 1'b0);
        check_output("zw_valid_cycles", 32'(last_valid_cycles), 32'd1);
        check_output("zw_done", 32'(last_done), 32'b01);
        check_output("zw_busy_after", 32'(seq_busy), 32'h0);
        check_output("zw_s_addr_kept", 32'(bus_if.s_addr), 32'h0A5);

        // Wait-state read from slave 1 for master 2.
        apply_stimulus(2, 2'd1, 1'b0, 12'h123, 8'h00, 3, 8'h5A, -1, 1'b0);
        check_output("ws_rdata", 32'(last_rdata), 32'h5A);
        check_output("ws_done", 32'(last_done), 32'b10);
        check_output("ws_error", 32'(last_err), 32'h0);
        check_output("ws_valid_cycles", 32'(last_valid_cycles), 32'd4);

        // Timeout on slave 3.
        apply_stimulus(1, 2'd3, 1'b0, 12'h3FF, 8'h00, NEVER, 8'h00, -1, 1'b0);
        check_output("to_valid_cycles", 32'(last_valid_cycles), 32'd16);
        check_output("to_done", 32'(last_done), 32'b01);
        check_output("to_error", 32'(last_err), 32'h1);
        check_output("to_err_count", 32'(err_count), 32'd1);

        // Ready arrives on the last permitted cycle.
        apply_stimulus(2, 2'd0, 1'b0, 12'h010, 8'h00, TIMEOUT - 1, 8'hC3, -1, 1'b0);
        check_output("late_error", 32'(last_err), 32'h0);
        check_output("late_rdata", 32'(last_rdata), 32'hC3);
        check_output("late_err_count", 32'(err_count), 32'd1);

        // Other slaves answering is ignored; ready of slave 0 arrives late.
        apply_stimulus(1, 2'd0, 1'b1, 12'h055, 8'h77, 5, 8'h00, -1, 1'b1);
        check_output("ws_noise_valid_cycles", 32'(last_valid_cycles), 32'd6);

        // Illegal grant in IDLE.
        idle_cycle(2'b11);
        check_output("illegal_proto_err", 32'(proto_err), 32'h1);
        check_output("illegal_busy", 32'(seq_busy), 32'h0);

        // Reset in the middle of a wait, then a normal transfer.
        done_before = done_count;
        apply_stimulus(1, 2'd1, 1'b1, 12'h0F0, 8'h11, 10, 8'h00, 3, 1'b0);
        check_output("rst_no_done", 32'(done_count), 32'(done_before));
        check_output("rst_proto_err", 32'(proto_err), 32'h0);
        idle_cycle(2'b00);
        apply_stimulus(1, 2'd2, 1'b1, 12'h0A5, 8'h3C, 0, 8'h00, -1, 1'b0);
        check_output("post_rst_done", 32'(last_done), 32'b01);

        // Randomised traffic.
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 5))
                0:       ra = 0;
                1:       ra = $urandom_range(1, 5);
                2:       ra = TIMEOUT - 1;
                3:       ra = TIMEOUT - 2;
                4:       ra = NEVER;
                default: ra = $urandom_range(0, TIMEOUT - 1);
            endcase
            ra_lim = (ra < TIMEOUT - 1) ? ra : TIMEOUT - 1;
            rs = ($urandom_range(0, 9) == 0) ? $urandom_range(0, ra_lim) : -1;
            apply_stimulus($urandom_range(1, 2), 2'($urandom), 1'($urandom),
                           ADDR_W'($urandom), DATA_W'($urandom), ra, DATA_W'($urandom),
                           rs, 1'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) idle_cycle(($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00);
        end

        // Error counter saturation.
        apply_reset(1);
        for (int t = 0; t < 257; t++) begin
            apply_stimulus($urandom_range(1, 2), 2'($urandom), 1'($urandom),
                           ADDR_W'($urandom), DATA_W'($urandom), NEVER, 8'h00, -1, 1'b0);
        end
        check_output("sat_err_count", 32'(err_count), 32'd255);
        idle_cycle(2'b00);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
